btn_event_ctrl: RTL and testbench
=================================

Name: btn_event_ctrl

Overview:
Sequences the debounced button levels (one debouncer output per Basys3 push-button) into discrete, arbitrated input events for the VGA control logic. Per-button FSMs detect presses and generate auto-repeat events while a button is held. A fixed-priority arbiter serialises simultaneous events onto a single valid/ready event port. The block sits between the debouncer bank and the display/cursor controller.

Parameters:
NUM_BTN, 5, number of button inputs (index 0 = highest priority)
ID_W, 3, width of event id; must be >= clog2(NUM_BTN)
HOLD_CYCLES, 50_000_000, cycles of continuous hold after the press sample before the first repeat event (0.5 s at 100 MHz)
REPEAT_CYCLES, 10_000_000, cycles between successive repeat events
CNT_W, 26, per-button counter width; must hold max(HOLD_CYCLES, REPEAT_CYCLES)-1
REPEAT_MASK, 5'b11111, per-button auto-repeat enable (bit i = button i)

Ports:
clk  in  1  system clock (100 MHz)
rst  in  1  synchronous, active-high reset
btn_level  in  NUM_BTN  debounced button levels, synchronous to clk
repeat_en  in  1  global auto-repeat enable
ovr_clr  in  1  clears sticky overrun
evt_ready  in  1  consumer accepts event
evt_valid  out  1  event present
evt_id  out  ID_W  index of button causing the event
evt_repeat  out  1  0 = initial press, 1 = auto-repeat
btn_held  out  NUM_BTN  bit i = 1 while FSM i is in HOLD or REPEAT
overrun  out  1  sticky: an event was dropped

Behaviour:
- Reset (rst=1 at posedge): evt_valid=0, evt_id=0, evt_repeat=0, btn_held=0, overrun=0, all pending flags=0, all FSMs IDLE, counters=0, edge register prev=all ones. A button already high at reset produces no event until it is released and pressed again.
- Edge detect: press[i] = btn_level[i] & ~prev[i]; prev updates every cycle.
- Per-button FSM (states IDLE, HOLD, REPEAT):
  - IDLE: press[i] -> HOLD, counter=0, raise press event (pending[i]=1, pend_rep[i]=0).
  - HOLD: level low -> IDLE. Otherwise counter increments, saturating at HOLD_CYCLES-1. At terminal count with repeat_en=1 and REPEAT_MASK[i]=1 -> REPEAT, counter=0, raise repeat event. With repeat disabled, it stays in HOLD at terminal; a later repeat_en=1 triggers the transition and event on the next cycle.
  - REPEAT: level low -> IDLE. Otherwise counter counts 0..REPEAT_CYCLES-1 and wraps. On the wrap, a repeat event is raised only if repeat_en=1 and REPEAT_MASK[i]=1.
  - Release seen in the same cycle as a terminal count: release wins and no event is raised.
  - btn_held[i] is registered from FSM state.
- Pending storage: one slot per button (pending[i], pend_rep[i]).
  - An event raised while pending[i]=1 and not being drained that cycle is dropped: the slot keeps the older event and overrun is set.
  - If the slot is drained and re-raised in the same cycle, the new event is stored and overrun is not set.
- Output arbiter: the output stage loads when evt_valid=0 or (evt_valid & evt_ready).
  - It selects the lowest-index pending[i], loads evt_id=i and evt_repeat=pend_rep[i], sets evt_valid=1, and clears pending[i] in the same cycle.
  - If nothing is pending, evt_valid goes to 0.
  - While evt_valid & ~evt_ready, evt_id and evt_repeat are held stable.
  - Throughput is 1 event/cycle under ready=1.
- Latency: press sampled at posedge k -> pending set after k -> evt_valid=1 after posedge k+1 (output free).
- overrun: set on any drop. Cleared by ovr_clr or rst. A drop in the same cycle as ovr_clr wins (stays 1).
- Reset mid-operation discards all pending and in-flight events, with no partial handshake.

Test Plan:
(Params NUM_BTN=5, HOLD_CYCLES=8, REPEAT_CYCLES=4; evt_ready=1 unless stated.)
1. btn_level[2] high for 3 cycles from posedge k -> exactly one event, id=2, repeat=0, evt_valid high only after posedge k+1.
2. btn_level[0] held 20 cycles, repeat_en=1 -> press event, then repeat events (repeat=1) 8, 12 and 16 cycles after the press event. Release -> no further events; btn_held[0] falls.
3. btn_level[1] and btn_level[3] rise in the same cycle -> id=1 then id=3 on consecutive cycles, no overrun.
4. evt_ready=0, three separate presses of btn 4 -> the first event is held stable on the output, the second sits pending, the third is dropped and overrun=1. evt_ready=1 -> two events delivered. ovr_clr -> overrun=0.
5. btn_level[0]=1 through and after reset -> no event. Release then re-press -> one press event.
6. btn 0 in REPEAT with evt_valid=1, assert rst one cycle -> next cycle evt_valid=0, btn_held=0, no event emitted while the button stays high.

Source files
------------

// File: rtl/btn_event_ctrl.sv
// btn_event_ctrl: per-button press/auto-repeat FSMs feeding one pending slot per
// button, drained by a fixed-priority arbiter onto a single valid/ready event port.
module btn_event_ctrl #(
  parameter int                 NUM_BTN       = 5,
  parameter int                 ID_W          = 3,
  parameter int                 HOLD_CYCLES   = 50_000_000,
  parameter int                 REPEAT_CYCLES = 10_000_000,
  parameter int                 CNT_W         = 26,
  parameter logic [NUM_BTN-1:0] REPEAT_MASK   = {NUM_BTN{1'b1}}
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_BTN-1:0] btn_level,
  input  logic               repeat_en,
  input  logic               ovr_clr,
  input  logic               evt_ready,
  output logic               evt_valid,
  output logic [ID_W-1:0]    evt_id,
  output logic               evt_repeat,
  output logic [NUM_BTN-1:0] btn_held,
  output logic               overrun
);

  typedef enum logic [1:0] {ST_IDLE, ST_HOLD, ST_REPEAT} state_e;

  localparam logic [CNT_W-1:0] HOLD_TC = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_TC  = CNT_W'(REPEAT_CYCLES - 1);

  state_e             state_q [NUM_BTN];
  state_e             state_d [NUM_BTN];
  logic [CNT_W-1:0]   cnt_q   [NUM_BTN];
  logic [CNT_W-1:0]   cnt_d   [NUM_BTN];
  logic [NUM_BTN-1:0] prev_q, prev_d;
  logic [NUM_BTN-1:0] pending_q, pending_d;
  logic [NUM_BTN-1:0] pend_rep_q, pend_rep_d;
  logic [NUM_BTN-1:0] btn_held_q, btn_held_d;
  logic               evt_valid_q, evt_valid_d;
  logic [ID_W-1:0]    evt_id_q, evt_id_d;
  logic               evt_repeat_q, evt_repeat_d;
  logic               overrun_q, overrun_d;

  logic [NUM_BTN-1:0] press, rep_ok, raise, raise_rep, drain, drop;
  logic               load;

  assign prev_d = btn_level;
  assign press  = btn_level & ~prev_q;
  assign rep_ok = {NUM_BTN{repeat_en}} & REPEAT_MASK;

  // A release always takes priority over a terminal count in the same cycle.
  always_comb begin
    raise      = '0;
    raise_rep  = '0;
    btn_held_d = '0;
    for (int i = 0; i < NUM_BTN; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      case (state_q[i])
        ST_IDLE: begin
          if (press[i]) begin
            state_d[i] = ST_HOLD;
            cnt_d[i]   = '0;
            raise[i]   = 1'b1;
          end
        end
        ST_HOLD: begin
          if (!btn_level[i]) begin
            state_d[i] = ST_IDLE;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == HOLD_TC) begin
            if (rep_ok[i]) begin
              state_d[i]   = ST_REPEAT;
              cnt_d[i]     = '0;
              raise[i]     = 1'b1;
              raise_rep[i] = 1'b1;
            end
          end else begin
            cnt_d[i] = cnt_q[i] + 1'b1;
          end
        end
        ST_REPEAT: begin
          if (!btn_level[i]) begin
            state_d[i] = ST_IDLE;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == REP_TC) begin
            cnt_d[i]     = '0;
            raise[i]     = rep_ok[i];
            raise_rep[i] = rep_ok[i];
          end else begin
            cnt_d[i] = cnt_q[i] + 1'b1;
          end
        end
        default: begin
          state_d[i] = ST_IDLE;
          cnt_d[i]   = '0;
        end
      endcase
      btn_held_d[i] = (state_d[i] != ST_IDLE);
    end
  end

  // Output stage reloads from the lowest-index pending slot whenever it is free.
  always_comb begin
    load         = ~evt_valid_q | evt_ready;
    evt_valid_d  = evt_valid_q;
    evt_id_d     = evt_id_q;
    evt_repeat_d = evt_repeat_q;
    drain        = '0;
    if (load) begin
      evt_valid_d = |pending_q;
      drain       = pending_q & (~pending_q + NUM_BTN'(1));
      for (int i = NUM_BTN - 1; i >= 0; i--) begin
        if (pending_q[i]) begin
          evt_id_d     = ID_W'(i);
          evt_repeat_d = pend_rep_q[i];
        end
      end
    end
  end

  always_comb begin
    pending_d  = pending_q & ~drain;
    pend_rep_d = pend_rep_q;
    drop       = '0;
    for (int i = 0; i < NUM_BTN; i++) begin
      if (raise[i]) begin
        if (pending_q[i] && !drain[i]) begin
          drop[i] = 1'b1;
        end else begin
          pending_d[i]  = 1'b1;
          pend_rep_d[i] = raise_rep[i];
        end
      end
    end
    overrun_d = (overrun_q & ~ovr_clr) | (|drop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_BTN; i++) begin
        state_q[i] <= ST_IDLE;
        cnt_q[i]   <= '0;
      end
      prev_q       <= '1;
      pending_q    <= '0;
      pend_rep_q   <= '0;
      btn_held_q   <= '0;
      evt_valid_q  <= 1'b0;
      evt_id_q     <= '0;
      evt_repeat_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_BTN; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      prev_q       <= prev_d;
      pending_q    <= pending_d;
      pend_rep_q   <= pend_rep_d;
      btn_held_q   <= btn_held_d;
      evt_valid_q  <= evt_valid_d;
      evt_id_q     <= evt_id_d;
      evt_repeat_q <= evt_repeat_d;
      overrun_q    <= overrun_d;
    end
  end

  assign evt_valid  = evt_valid_q;
  assign evt_id     = evt_id_q;
  assign evt_repeat = evt_repeat_q;
  assign btn_held   = btn_held_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_btn_event_ctrl.sv
// Self-checking bench for btn_event_ctrl: a hold-time based reference model
// compared every cycle, plus directed scenarios with literal expectations.
module tb_btn_event_ctrl;

  localparam int       NB    = 5;
  localparam int       HOLD  = 8;
  localparam int       REP   = 4;
  localparam bit [4:0] MASK  = 5'b11111;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] btn_level;
  logic       repeat_en;
  logic       ovr_clr;
  logic       evt_ready;
  logic       evt_valid;
  logic [2:0] evt_id;
  logic       evt_repeat;
  logic [4:0] btn_held;
  logic       overrun;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int n_evt    = 0;
  int n_rep    = 0;
  int evt_cyc[$];

  btn_event_ctrl #(
    .NUM_BTN(NB), .ID_W(3), .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP),
    .CNT_W(4), .REPEAT_MASK(MASK)
  ) dut (
    .clk(clk), .rst(rst), .btn_level(btn_level), .repeat_en(repeat_en),
    .ovr_clr(ovr_clr), .evt_ready(evt_ready), .evt_valid(evt_valid),
    .evt_id(evt_id), .evt_repeat(evt_repeat), .btn_held(btn_held),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at cycle %0d", name, actual, expected, cyc);
    end
  endtask

  task automatic applyStimulus(input logic [4:0] lvl, input int cycles);
    btn_level = lvl;
    repeat (cycles) @(negedge clk);
  endtask

  // Reference model: a button's event times follow from how long it has been held.
  int       m_age   [NB];
  int       m_entry [NB];
  bit       m_in_rep[NB];
  bit [4:0] m_prev, m_pend, m_prep, m_held, old_pend, raise_v, rrep_v;
  bit       m_valid, m_rep, m_ovr, rok;
  int       m_id, sel;

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      m_prev = '1; m_pend = '0; m_prep = '0; m_held = '0;
      m_valid = 0; m_rep = 0; m_ovr = 0; m_id = 0;
      for (int i = 0; i < NB; i++) begin
        m_age[i] = -1; m_in_rep[i] = 0; m_entry[i] = 0;
      end
    end else begin
      old_pend = m_pend;
      sel = -1;
      if (!m_valid || evt_ready) begin
        for (int i = NB - 1; i >= 0; i--) if (old_pend[i]) sel = i;
        m_valid = (sel >= 0);
        if (sel >= 0) begin
          m_id  = sel;
          m_rep = m_prep[sel];
        end
      end
      raise_v = '0;
      rrep_v  = '0;
      for (int i = 0; i < NB; i++) begin
        rok = repeat_en && MASK[i];
        if (!btn_level[i]) begin
          m_age[i] = -1;
          m_in_rep[i] = 0;
        end else if (m_age[i] < 0) begin
          if (!m_prev[i]) begin
            m_age[i] = 0;
            raise_v[i] = 1;
          end
        end else begin
          m_age[i]++;
          if (!m_in_rep[i]) begin
            if (m_age[i] >= HOLD && rok) begin
              m_in_rep[i] = 1;
              m_entry[i]  = m_age[i];
              raise_v[i]  = 1;
              rrep_v[i]   = 1;
            end
          end else if ((m_age[i] - m_entry[i]) % REP == 0 && rok) begin
            raise_v[i] = 1;
            rrep_v[i]  = 1;
          end
        end
        m_prev[i] = btn_level[i];
        m_held[i] = (m_age[i] >= 0);
      end
      if (ovr_clr) m_ovr = 0;
      for (int i = 0; i < NB; i++) begin
        if (raise_v[i]) begin
          if (old_pend[i] && sel != i) m_ovr = 1;
          else begin
            m_pend[i] = 1;
            m_prep[i] = rrep_v[i];
          end
        end else if (sel == i) begin
          m_pend[i] = 0;
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    checkOutput("cyc_valid", evt_valid, m_valid);
    if (m_valid) begin
      checkOutput("cyc_id", evt_id, m_id);
      checkOutput("cyc_repeat", evt_repeat, m_rep);
    end
    checkOutput("cyc_held", btn_held, m_held);
    checkOutput("cyc_overrun", overrun, m_ovr);
  end

  // Handshakes observed with pre-edge output values.
  always @(posedge clk) begin
    if (!rst && evt_valid && evt_ready) begin
      n_evt++;
      if (evt_repeat) n_rep++;
      evt_cyc.push_back(cyc);
    end
  end

  initial begin
    rst = 1; btn_level = '0; repeat_en = 1; ovr_clr = 0; evt_ready = 1;
    repeat (2) @(negedge clk);
    checkOutput("rst_valid", evt_valid, 0);
    checkOutput("rst_id", evt_id, 0);
    checkOutput("rst_repeat", evt_repeat, 0);
    checkOutput("rst_held", btn_held, 0);
    checkOutput("rst_overrun", overrun, 0);
    rst = 0;
    applyStimulus(5'b00000, 2);

    // Single short press of button 2
    n_evt = 0;
    btn_level = 5'b00100;
    @(negedge clk);
    checkOutput("t1_latency_valid", evt_valid, 0);
    @(negedge clk);
    checkOutput("t1_valid", evt_valid, 1);
    checkOutput("t1_id", evt_id, 2);
    checkOutput("t1_repeat", evt_repeat, 0);
    applyStimulus(5'b00100, 1);
    applyStimulus(5'b00000, 4);
    checkOutput("t1_count", n_evt, 1);

    // Long hold of button 0 with auto-repeat
    n_evt = 0; n_rep = 0; evt_cyc.delete();
    applyStimulus(5'b00001, 20);
    checkOutput("t2_held", btn_held[0], 1);
    applyStimulus(5'b00000, 3);
    checkOutput("t2_released", btn_held[0], 0);
    applyStimulus(5'b00000, 3);
    checkOutput("t2_count", n_evt, 4);
    checkOutput("t2_repeats", n_rep, 3);
    if (evt_cyc.size() >= 4) begin
      checkOutput("t2_rep1_gap", evt_cyc[1] - evt_cyc[0], 8);
      checkOutput("t2_rep2_gap", evt_cyc[2] - evt_cyc[0], 12);
      checkOutput("t2_rep3_gap", evt_cyc[3] - evt_cyc[0], 16);
    end

    // Simultaneous presses of buttons 1 and 3
    n_evt = 0;
    btn_level = 5'b01010;
    @(negedge clk);
    @(negedge clk);
    checkOutput("t3_first_valid", evt_valid, 1);
    checkOutput("t3_first_id", evt_id, 1);
    @(negedge clk);
    checkOutput("t3_second_valid", evt_valid, 1);
    checkOutput("t3_second_id", evt_id, 3);
    applyStimulus(5'b00000, 3);
    checkOutput("t3_count", n_evt, 2);
    checkOutput("t3_overrun", overrun, 0);

    // Back-pressure: three presses of button 4, third one dropped
    evt_ready = 0; n_evt = 0;
    applyStimulus(5'b10000, 2);
    applyStimulus(5'b00000, 2);
    applyStimulus(5'b10000, 2);
    applyStimulus(5'b00000, 2);
    checkOutput("t4_no_overrun_yet", overrun, 0);
    applyStimulus(5'b10000, 2);
    applyStimulus(5'b00000, 2);
    checkOutput("t4_overrun", overrun, 1);
    checkOutput("t4_stall_valid", evt_valid, 1);
    checkOutput("t4_stall_id", evt_id, 4);
    evt_ready = 1;
    applyStimulus(5'b00000, 4);
    checkOutput("t4_count", n_evt, 2);
    checkOutput("t4_drained", evt_valid, 0);
    checkOutput("t4_sticky", overrun, 1);
    ovr_clr = 1;
    @(negedge clk);
    ovr_clr = 0;
    checkOutput("t4_cleared", overrun, 0);

    // Button held through reset
    btn_level = 5'b00001; rst = 1;
    applyStimulus(5'b00001, 2);
    rst = 0; n_evt = 0;
    applyStimulus(5'b00001, 5);
    checkOutput("t5_no_event", n_evt, 0);
    checkOutput("t5_not_held", btn_held[0], 0);
    applyStimulus(5'b00000, 2);
    applyStimulus(5'b00001, 3);
    applyStimulus(5'b00000, 3);
    checkOutput("t5_repress_count", n_evt, 1);

    // Reset while button 0 is repeating with an event on the output
    applyStimulus(5'b00001, 10);
    checkOutput("t6_pre_valid", evt_valid, 1);
    checkOutput("t6_pre_repeat", evt_repeat, 1);
    checkOutput("t6_pre_held", btn_held[0], 1);
    rst = 1;
    @(negedge clk);
    rst = 0;
    checkOutput("t6_rst_valid", evt_valid, 0);
    checkOutput("t6_rst_held", btn_held, 0);
    n_evt = 0;
    applyStimulus(5'b00001, 12);
    checkOutput("t6_no_event", n_evt, 0);
    checkOutput("t6_quiet_valid", evt_valid, 0);
    applyStimulus(5'b00000, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
